rr_switch_alloc: RTL

Parametrised switch allocator for the NoC router. It holds one independent arbiter per output port, and each arbiter grants an output to one input for the duration of a packet. Arbitration is round-robin or fixed-priority, gated per output by a downstream enable. It sits between the input-port route-compute stage and the crossbar select logic, and it replaces the fixed 5-port, per-output arbiter bank with a configurable, packet-locking block.

---
 rtl/noc_arb_pkg.sv | 21 ++
 rtl/rr_arb_cell.sv | 106 ++++++++++
 rtl/rr_switch_alloc.sv | 60 ++++++
 3 files changed

// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC switch allocator.
//   ARB_RR / ARB_FIXED : arbitration mode encodings for the MODE parameter
//   alloc_state_t      : per-output allocation state (IDLE, LOCKED)
//   idx_w()            : width of a port index for a given port count
package noc_arb_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Port-index width; never narrower than one bit so a 1-port build still
    // has a legal index register.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arb_cell.sv
// One output port of the switch allocator: allocation FSM, owner register,
// priority pointer and winner search.
//   clk, rst : clock, asynchronous active-low reset
//   req      : req[i] = input i has a flit for this output
//   tail     : tail[i] = the current flit at input i is a tail
//   en       : this output can accept a flit this cycle
//   gnt      : gnt[i] = this output is owned by input i (one-hot or zero)
//   busy     : high while the output is LOCKED (doubles as the state view)
//   ptr      : current round-robin pointer
module rr_arb_cell
    import noc_arb_pkg::*;
#(
    parameter int  NUM_PORTS = 5,
    parameter int  MODE      = ARB_RR,
    parameter int  LOCK_PKT  = 1,
    localparam int PW        = idx_w(NUM_PORTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] tail,
    input  logic                 en,
    output logic [NUM_PORTS-1:0] gnt,
    output logic                 busy,
    output logic [PW-1:0]        ptr
);

    alloc_state_t         state_q, state_d;
    logic [PW-1:0]        owner_q, owner_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic [PW-1:0]        start;
    logic [PW-1:0]        win;
    logic                 found;
    logic                 xfer;
    logic                 rel;

    // Fixed priority is a round-robin search that always starts at input 0.
    assign start = (MODE == ARB_FIXED) ? '0 : ptr_q;

    // Two passes: first the inputs at or above start, then wrap to the
    // lowest requester. The second pass only matters if the first found none.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[i] && (i >= int'(start))) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                win   = PW'(i);
            end
        end
    end

    assign xfer = (state_q == LOCKED) && req[owner_q] && en;
    assign rel  = xfer && ((LOCK_PKT == 0) || tail[owner_q]);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        case (state_q)
            IDLE: begin
                if (en && found) begin
                    state_d = LOCKED;
                    owner_d = win;
                    gnt_d   = NUM_PORTS'(1) << win;
                end
            end
            LOCKED: begin
                // Other requesters are ignored here; only the owner's
                // release returns the output to arbitration.
                if (rel) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = (owner_q == PW'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign busy = (state_q == LOCKED);
    assign ptr  = ptr_q;

endmodule

// File: rtl/rr_switch_alloc.sv
// Switch allocator: one independent packet-locking arbiter per output port.
//   clk, rst : clock, asynchronous active-low reset
//   req_i    : req_i[i][o] = input i has a flit for output o
//   tail_i   : tail_i[i] = current flit at input i is a tail
//   en_i     : en_i[o] = output o has downstream credit this cycle
//   gnt_o    : gnt_o[o][i] = output o owned by input i (registered)
//   busy_o   : busy_o[o] = output o is LOCKED (registered)
//   dbg_ptr  : dbg_ptr[o] = round-robin pointer of output o
//
// Handshake: a flit moves from input i to output o in a cycle where
// gnt_o[o][i], req_i[i][o] and en_i[o] are all high. req_i acts as valid,
// en_i as ready; gnt_o only selects who may use the output. Neither side may
// assume a transfer without all three.
module rr_switch_alloc
    import noc_arb_pkg::*;
#(
    parameter int NUM_PORTS = 5,
    parameter int MODE      = ARB_RR,
    parameter int LOCK_PKT  = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        req_i,
    input  logic [NUM_PORTS-1:0]                       tail_i,
    input  logic [NUM_PORTS-1:0]                       en_i,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]        gnt_o,
    output logic [NUM_PORTS-1:0]                       busy_o,
    output logic [NUM_PORTS-1:0][idx_w(NUM_PORTS)-1:0] dbg_ptr
);

    // Each cell wants the column of requests aimed at its output.
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_t;

    always_comb begin
        req_t = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                req_t[o][i] = req_i[i][o];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_out
        rr_arb_cell #(
            .NUM_PORTS (NUM_PORTS),
            .MODE      (MODE),
            .LOCK_PKT  (LOCK_PKT)
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .req  (req_t[o]),
            .tail (tail_i),
            .en   (en_i[o]),
            .gnt  (gnt_o[o]),
            .busy (busy_o[o]),
            .ptr  (dbg_ptr[o])
        );
    end

endmodule
